// File: rtl/op_sweep_ctrl.sv
// Sequencer that drives an operand/selector pair into a selectable-operation
// datapath, waits for the datapath to settle, and collects the result for one
// selector code or for all four codes in turn.
module op_sweep_ctrl #(
    parameter int SETTLE = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [3:0]  a_in,
    input  logic        sweep_all,
    input  logic [1:0]  sel_in,
    input  logic [3:0]  res_in,
    output logic [3:0]  a_out,
    output logic [1:0]  sel_out,
    output logic        busy,
    output logic        done,
    output logic [15:0] results,
    output logic [3:0]  valid_mask
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_CAPT = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [3:0] SETTLE_C = 4'(SETTLE);

    state_t     state;
    state_t     state_next;
    logic [3:0] cnt;
    logic       mode;
    logic       more;

    // A sweep continues until slot 3 has been captured; sel_out never wraps.
    assign more = mode && (sel_out != 2'd3);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode and status outputs.
    always_comb begin
        state_next = state;
        busy       = 1'b1;
        done       = 1'b0;
        case (state)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) state_next = ST_WAIT;
            end
            ST_WAIT: begin
                // Counter is loaded with SETTLE, so WAIT lasts SETTLE cycles.
                if (cnt <= 4'd1) state_next = ST_CAPT;
            end
            ST_CAPT: begin
                state_next = more ? ST_WAIT : ST_DONE;
            end
            ST_DONE: begin
                done       = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Operand/selector registers, settle counter and result collection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_out      <= 4'd0;
            sel_out    <= 2'd0;
            mode       <= 1'b0;
            cnt        <= 4'd0;
            results    <= 16'd0;
            valid_mask <= 4'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    // Inputs are captured only here, so later changes are ignored.
                    if (start) begin
                        a_out      <= a_in;
                        mode       <= sweep_all;
                        sel_out    <= sweep_all ? 2'd0 : sel_in;
                        results    <= 16'd0;
                        valid_mask <= 4'd0;
                        cnt        <= SETTLE_C;
                    end
                end
                ST_WAIT: begin
                    cnt <= cnt - 4'd1;
                end
                ST_CAPT: begin
                    results[{sel_out, 2'b00} +: 4] <= res_in;
                    valid_mask[sel_out]            <= 1'b1;
                    if (more) begin
                        sel_out <= sel_out + 2'd1;
                        cnt     <= SETTLE_C;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_op_sweep_ctrl.sv
// Directed bench for op_sweep_ctrl: two instances (SETTLE=1 and SETTLE=3)
// each driving a modelled datapath res = (a + sel) mod 16.
module tb_op_sweep_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start1 = 1'b0;
    logic        start3 = 1'b0;
    logic [3:0]  a_in = 4'd0;
    logic        sweep_all = 1'b0;
    logic [1:0]  sel_in = 2'd0;

    logic [3:0]  res1, res3, a_out1, a_out3;
    logic [1:0]  sel_out1, sel_out3;
    logic        busy1, busy3, done1, done3;
    logic [15:0] results1, results3;
    logic [3:0]  mask1, mask3;

    int n_total = 0;
    int n_bad   = 0;
    bit use3    = 1'b0;

    always #5 clk = ~clk;

    // Datapath model.
    assign res1 = a_out1 + 4'(sel_out1);
    assign res3 = a_out3 + 4'(sel_out3);

    op_sweep_ctrl #(.SETTLE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .a_in(a_in),
        .sweep_all(sweep_all), .sel_in(sel_in), .res_in(res1),
        .a_out(a_out1), .sel_out(sel_out1), .busy(busy1), .done(done1),
        .results(results1), .valid_mask(mask1)
    );

    op_sweep_ctrl #(.SETTLE(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .a_in(a_in),
        .sweep_all(sweep_all), .sel_in(sel_in), .res_in(res3),
        .a_out(a_out3), .sel_out(sel_out3), .busy(busy3), .done(done3),
        .results(results3), .valid_mask(mask3)
    );

    logic [3:0]  m_a;
    logic [1:0]  m_sel;
    logic        m_busy, m_done;
    logic [15:0] m_res;
    logic [3:0]  m_mask;
    assign m_a    = use3 ? a_out3   : a_out1;
    assign m_sel  = use3 ? sel_out3 : sel_out1;
    assign m_busy = use3 ? busy3    : busy1;
    assign m_done = use3 ? done3    : done1;
    assign m_res  = use3 ? results3 : results1;
    assign m_mask = use3 ? mask3    : mask1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_a"},    32'(m_a),    32'd0);
        chk({tag, "_sel"},  32'(m_sel),  32'd0);
        chk({tag, "_busy"}, 32'(m_busy), 32'd0);
        chk({tag, "_done"}, 32'(m_done), 32'd0);
        chk({tag, "_res"},  32'(m_res),  32'd0);
        chk({tag, "_mask"}, 32'(m_mask), 32'd0);
    endtask

    // Runs one operation; cycle 0 is the start-accept edge, cycle c is
    // sampled on the falling edge after rising edge c-1. A second start
    // pulse is injected in cycle inj (0 = none).
    task automatic run_op(input bit u3, input int settle, input logic [3:0] a,
                          input bit sw, input logic [1:0] sl,
                          input logic [15:0] er, input logic [3:0] em,
                          input int edone, input int inj, input string tag);
        int first_done;
        int n_done;
        use3 = u3;
        @(negedge clk);
        a_in = a; sweep_all = sw; sel_in = sl;
        if (u3) start3 = 1'b1; else start1 = 1'b1;
        @(posedge clk);
        first_done = -1;
        n_done = 0;
        for (int c = 1; c <= edone + 1; c++) begin
            @(negedge clk);
            start1 = 1'b0;
            start3 = 1'b0;
            if (c == inj) begin
                start1 = !u3; start3 = u3;
                a_in = 4'h1; sweep_all = 1'b0; sel_in = 2'd1;
            end
            if (m_done) begin
                n_done++;
                if (first_done < 0) first_done = c;
            end
            chk($sformatf("%s_busy_c%0d", tag, c), 32'(m_busy), 32'(c <= edone));
            if (c <= edone - 1) begin
                chk($sformatf("%s_a_c%0d", tag, c), 32'(m_a), 32'(a));
                if (sw)
                    chk($sformatf("%s_sel_c%0d", tag, c), 32'(m_sel), 32'((c - 1) / (settle + 1)));
                else
                    chk($sformatf("%s_sel_c%0d", tag, c), 32'(m_sel), 32'(sl));
            end
        end
        chk({tag, "_done_cycle"}, 32'(first_done), 32'(edone));
        chk({tag, "_done_count"}, 32'(n_done), 32'd1);
        chk({tag, "_results"}, 32'(m_res), 32'(er));
        chk({tag, "_mask"}, 32'(m_mask), 32'(em));
        repeat (2) @(negedge clk);
        chk({tag, "_results_hold"}, 32'(m_res), 32'(er));
        chk({tag, "_mask_hold"}, 32'(m_mask), 32'(em));
        chk({tag, "_idle"}, 32'(m_busy), 32'd0);
    endtask

    initial begin
        // Reset state for both instances.
        #2;
        use3 = 1'b0; #1 check_all_zero("rst1");
        use3 = 1'b1; #1 check_all_zero("rst3");
        @(negedge clk);
        rst_n = 1'b1;

        run_op(1'b0, 1, 4'hA, 1'b1, 2'd0, 16'hDCBA, 4'b1111, 9, 0, "sweep_s1");
        run_op(1'b0, 1, 4'h3, 1'b0, 2'd2, 16'h0500, 4'b0100, 3, 0, "single_s1");
        run_op(1'b1, 3, 4'hF, 1'b1, 2'd0, 16'h210F, 4'b1111, 17, 0, "sweep_s3");
        run_op(1'b1, 3, 4'h7, 1'b0, 2'd1, 16'h0080, 4'b0010, 5, 0, "single_s3");
        run_op(1'b0, 1, 4'h4, 1'b1, 2'd0, 16'h7654, 4'b1111, 9, 3, "ignored_start");

        // Reset during the second WAIT of a sweep, then a fresh sweep.
        use3 = 1'b0;
        @(negedge clk);
        a_in = 4'h2; sweep_all = 1'b1; start1 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start1 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("midrst_pre_busy", 32'(busy1), 32'd1);
        chk("midrst_pre_sel", 32'(sel_out1), 32'd1);
        #2 rst_n = 1'b0;
        #1 check_all_zero("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        run_op(1'b0, 1, 4'h5, 1'b1, 2'd0, 16'h8765, 4'b1111, 9, 0, "after_rst");

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
